// File: rtl/mc8051_mem_sched.sv
// Shared memory port scheduler: fixed-priority grant (S5 > S3 > S2), one access at a time, wait-state handshake with timeout.
// Latency: arbitration cycle + >=1 BUSY cycle + ACK cycle (min 3); requesters are held off by keeping req high until their ack.
module mc8051_mem_sched #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255,
  parameter logic [7:0] ERR_RDATA   = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_s2_req,
  input  logic [15:0] i_s2_addr,
  input  logic        i_s3_req,
  input  logic [15:0] i_s3_addr,
  input  logic        i_s5_req,
  input  logic [15:0] i_s5_addr,
  input  logic [7:0]  i_s5_wdata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [7:0]  o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_s2_ack,
  output logic        o_s3_ack,
  output logic        o_s5_ack,
  output logic [7:0]  o_rdata,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  typedef enum logic [1:0] {GNT_S2, GNT_S3, GNT_S5} gnt_t;

  state_t     state;
  gnt_t       gnt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       timeout;

  // Saturating so a large TIMEOUT_CYC can never be skipped by wrap-around.
  assign cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign timeout = (cnt_nxt >= TIMEOUT_CYC);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      gnt         <= GNT_S2;
      cnt         <= 8'h00;
      o_mem_addr  <= 16'h0000;
      o_mem_rd    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_wdata <= 8'h00;
      o_s2_ack    <= 1'b0;
      o_s3_ack    <= 1'b0;
      o_s5_ack    <= 1'b0;
      o_rdata     <= 8'h00;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 8'h00;
          if (i_s5_req) begin
            gnt         <= GNT_S5;
            o_mem_addr  <= i_s5_addr;
            o_mem_wdata <= i_s5_wdata;
            o_mem_wr    <= 1'b1;
            o_busy      <= 1'b1;
            state       <= BUSY;
          end else if (i_s3_req) begin
            gnt        <= GNT_S3;
            o_mem_addr <= i_s3_addr;
            o_mem_rd   <= 1'b1;
            o_busy     <= 1'b1;
            state      <= BUSY;
          end else if (i_s2_req) begin
            gnt        <= GNT_S2;
            o_mem_addr <= i_s2_addr;
            o_mem_rd   <= 1'b1;
            o_busy     <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt_nxt;
          if (i_mem_ready || timeout) begin
            // o_mem_rd still reflects the granted access type here.
            if (o_mem_rd) o_rdata <= i_mem_ready ? i_mem_rdata : ERR_RDATA;
            o_err    <= !i_mem_ready;
            o_mem_rd <= 1'b0;
            o_mem_wr <= 1'b0;
            o_s2_ack <= (gnt == GNT_S2);
            o_s3_ack <= (gnt == GNT_S3);
            o_s5_ack <= (gnt == GNT_S5);
            state    <= ACK;
          end
        end
        ACK: begin
          o_s2_ack <= 1'b0;
          o_s3_ack <= 1'b0;
          o_s5_ack <= 1'b0;
          o_err    <= 1'b0;
          o_busy   <= 1'b0;
          cnt      <= 8'h00;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc8051_mem_sched.sv
// Scoreboarded bench for mc8051_mem_sched: directed accesses, memory responder and requester models, monitor on the falling edge.
module tb_mc8051_mem_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s2_req, s3_req, s5_req;
  logic [15:0] s2_addr, s3_addr, s5_addr;
  logic [7:0]  s5_wdata;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic [7:0]  mem_rdata;
  logic        s2_ack, s3_ack, s5_ack;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;

  always #5 clk = ~clk;

  mc8051_mem_sched #(.TIMEOUT_CYC(8'd4), .ERR_RDATA(8'hFF)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s2_req(s2_req), .i_s2_addr(s2_addr),
    .i_s3_req(s3_req), .i_s3_addr(s3_addr),
    .i_s5_req(s5_req), .i_s5_addr(s5_addr), .i_s5_wdata(s5_wdata),
    .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr), .o_mem_wdata(mem_wdata),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata),
    .o_s2_ack(s2_ack), .o_s3_ack(s3_ack), .o_s5_ack(s5_ack),
    .o_rdata(rdata), .o_err(err), .o_busy(busy)
  );

  typedef struct {
    logic [2:0]  ack;    // {s5,s3,s2}
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    int          ncyc;   // strobe cycles expected
  } exp_t;

  typedef struct {
    int         wt;      // wait cycles before ready
    logic [7:0] rd;
  } rsp_t;

  exp_t sbq[$];
  rsp_t memq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] ack, input logic wr, input logic [15:0] addr,
                          input logic [7:0] wd, input logic [7:0] rd, input logic e, input int ncyc);
    exp_t x;
    x.ack = ack; x.wr = wr; x.addr = addr; x.wdata = wd; x.rdata = rd; x.err = e; x.ncyc = ncyc;
    sbq.push_back(x);
  endtask

  task automatic push_rsp(input int wt, input logic [7:0] rd);
    rsp_t r;
    r.wt = wt; r.rd = rd;
    memq.push_back(r);
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (sbq.size() == 0 && !busy && !s2_req && !s3_req && !s5_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_drain"}, 32'(ok), 32'd1);
  endtask

  // Monitor: checks every strobe cycle and every ack against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        if (sbq.size() == 0) chk("unexpected_strobe", {30'd0, mem_rd, mem_wr}, 32'd0);
        else begin
          e = sbq[0];
          chk("strobe_addr_data",
              32'({mem_rd, mem_wr, mem_addr, (e.wr ? mem_wdata : 8'h00)}),
              32'({!e.wr, e.wr, e.addr, (e.wr ? e.wdata : 8'h00)}));
          mon_cyc++;
        end
      end
      if (s2_ack || s3_ack || s5_ack || err) begin
        if (sbq.size() == 0) chk("unexpected_ack", {28'd0, s5_ack, s3_ack, s2_ack, err}, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("ack_id", 32'({s5_ack, s3_ack, s2_ack}), 32'(e.ack));
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("err", 32'(err), 32'(e.err));
          chk("strobe_cycles", 32'(mon_cyc), 32'(e.ncyc));
        end
        mon_cyc = 0;
      end
    end
  end

  // Memory responder and requester model: reqs drop during their ack cycle.
  initial begin
    rsp_t cur;
    bit   mact = 1'b0;
    int   mcnt = 0;
    cur.wt = 0; cur.rd = 8'h00;
    forever begin
      @(negedge clk);
      if (s2_ack) s2_req = 1'b0;
      if (s3_ack) s3_req = 1'b0;
      if (s5_ack) s5_req = 1'b0;
      if (mem_rd || mem_wr) begin
        if (!mact && memq.size() > 0) begin
          cur = memq.pop_front();
          mact = 1'b1;
          mcnt = 0;
        end
        if (mact && mcnt == cur.wt) begin
          mem_ready = 1'b1;
          mem_rdata = cur.rd;
          mact = 1'b0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 8'hEE;
        end
        mcnt++;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 8'hEE;
        mact = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s2_req = 1'b0; s3_req = 1'b0; s5_req = 1'b0;
    s2_addr = 16'h0; s3_addr = 16'h0; s5_addr = 16'h0; s5_wdata = 8'h0;
    mem_ready = 1'b0; mem_rdata = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({busy, mem_rd, mem_wr, s5_ack, s3_ack, s2_ack, err}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'({mem_wdata, rdata}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single S2 read, ready in first BUSY cycle.
    push_exp(3'b001, 1'b0, 16'h0040, 8'h00, 8'h5A, 1'b0, 1);
    push_rsp(0, 8'h5A);
    @(posedge clk); #1 s2_addr = 16'h0040; s2_req = 1'b1;
    @(posedge clk); #1 chk("t1_rd_cycle1", 32'(mem_rd), 32'd1);
    @(posedge clk); #1 chk("t1_ack_cycle2", 32'({s2_ack, rdata}), 32'({1'b1, 8'h5A}));
    wait_idle("t1");

    // S5 write with 3 wait states; o_rdata must stay 5A.
    push_exp(3'b100, 1'b1, 16'h00E0, 8'h3C, 8'h5A, 1'b0, 4);
    push_rsp(3, 8'h00);
    s5_addr = 16'h00E0; s5_wdata = 8'h3C; s5_req = 1'b1;
    wait_idle("t2");

    // All three together: S5, then S3, then S2.
    push_exp(3'b100, 1'b1, 16'h0100, 8'h11, 8'h5A, 1'b0, 2);
    push_exp(3'b010, 1'b0, 16'h0200, 8'h00, 8'hA1, 1'b0, 1);
    push_exp(3'b001, 1'b0, 16'h0300, 8'h00, 8'hB2, 1'b0, 3);
    push_rsp(1, 8'h00);
    push_rsp(0, 8'hA1);
    push_rsp(2, 8'hB2);
    s5_addr = 16'h0100; s5_wdata = 8'h11; s3_addr = 16'h0200; s2_addr = 16'h0300;
    s5_req = 1'b1; s3_req = 1'b1; s2_req = 1'b1;
    wait_idle("t3");

    // S3 read that never completes: 4 BUSY cycles, then error ack with FF.
    push_exp(3'b010, 1'b0, 16'h0055, 8'h00, 8'hFF, 1'b1, 4);
    s3_addr = 16'h0055; s3_req = 1'b1;
    wait_idle("t4");

    // Requester drops req mid-BUSY: access still completes, no regrant.
    push_exp(3'b010, 1'b0, 16'h0123, 8'h00, 8'h9E, 1'b0, 3);
    push_rsp(2, 8'h9E);
    s3_addr = 16'h0123; s3_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 s3_req = 1'b0;
    wait_idle("t6");
    repeat (5) @(posedge clk);
    #1 chk("t6_no_regrant", 32'({busy, mem_rd, mem_wr}), 32'd0);

    // Reset in the middle of BUSY: strobes drop, no ack, then regrant.
    push_exp(3'b001, 1'b0, 16'h0077, 8'h00, 8'h00, 1'b0, 0);
    s2_addr = 16'h0077; s2_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 chk("t5_busy_before_rst", 32'({busy, mem_rd}), 32'd3);
    rst_n = 1'b0;
    #1 chk("t5_rst_strobe", 32'({mem_rd, mem_wr, busy, s5_ack, s3_ack, s2_ack}), 32'd0);
    sbq.delete();
    mon_cyc = 0;
    repeat (2) @(posedge clk);
    #1 chk("t5_rst_rdata", 32'(rdata), 32'd0);
    push_exp(3'b001, 1'b0, 16'h0077, 8'h00, 8'hC3, 1'b0, 1);
    push_rsp(0, 8'hC3);
    rst_n = 1'b1;
    wait_idle("t5");

    chk("memq_consumed", 32'(memq.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
